// File: rtl/lcm_init_seq.sv
// lcm_init_seq
//   Walks the LCM init-parameter ROM from address 0 and turns its records
//   into byte-streamed DSI command packets and timed millisecond delays.
//   Record format: LEN=0x00 ends the table, LEN=0xFF is a delay record whose
//   next byte is the wait in ms, any other LEN is a packet of LEN bytes.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_start        single-cycle pulse, starts the sequence at address 0
//   o_rom_addr     ROM read address
//   i_rom_rd_data  ROM read data, valid ROM_LAT cycles after o_rom_addr changes
//   o_pkt_valid    o_pkt_data holds a valid byte
//   i_pkt_ready    downstream accepts the byte when valid & ready
//   o_pkt_data     packet byte (first byte is the DCS command)
//   o_pkt_sop      first byte of a packet
//   o_pkt_eop      last byte of a packet
//   o_busy         sequence in progress
//   o_done         sticky, table end reached (also set on overrun)
//   o_err          sticky, address overrun before the end record
module lcm_init_seq #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int ROM_LAT    = 1,
  parameter int CLK_PER_MS = 50000,
  parameter int MS_WIDTH   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_rd_data,
  output logic                  o_pkt_valid,
  input  logic                  i_pkt_ready,
  output logic [DATA_WIDTH-1:0] o_pkt_data,
  output logic                  o_pkt_sop,
  output logic                  o_pkt_eop,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int CYC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int LAT_W = 2;
  localparam logic [CYC_W-1:0]      CYC_RELOAD = CYC_W'(CLK_PER_MS - 1);
  localparam logic [CYC_W-1:0]      CYC_ZERO   = {CYC_W{1'b0}};
  localparam logic [CYC_W-1:0]      CYC_ONE    = CYC_W'(1);
  localparam logic [LAT_W-1:0]      LAT_LAST   = LAT_W'(ROM_LAT - 1);
  localparam logic [LAT_W-1:0]      LAT_ZERO   = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0]      LAT_ONE    = LAT_W'(1);
  localparam logic [DATA_WIDTH-1:0] LEN_END    = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] LEN_DLY    = {DATA_WIDTH{1'b1}};
  localparam logic [MS_WIDTH-1:0]   MS_ZERO    = {MS_WIDTH{1'b0}};
  localparam logic [MS_WIDTH-1:0]   MS_ONE     = MS_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ADDR_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   ADDR_ONE   = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_HDR  = 3'd1,
    S_DECODE  = 3'd2,
    S_RD_BYTE = 3'd3,
    S_SEND    = 3'd4,
    S_RD_DLY  = 3'd5,
    S_DELAY   = 3'd6,
    S_FIN     = 3'd7
  } state_t;

  state_t                r_state;
  // One bit wider than the ROM address so a wrap past the last entry is visible.
  logic [ADDR_WIDTH:0]   r_addr;
  logic [LAT_W-1:0]      r_lat;
  logic [DATA_WIDTH-1:0] r_hdr;
  logic [7:0]            r_remain;
  logic                  r_first;
  logic [MS_WIDTH-1:0]   r_ms;
  logic [CYC_W-1:0]      r_cyc;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_sop;
  logic                  r_eop;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_rd_last;
  logic                  w_ovr;
  logic [ADDR_WIDTH:0]   w_addr_nxt;
  logic                  w_nxt_ovr;
  logic [MS_WIDTH-1:0]   w_ms_in;

  assign w_rd_last  = (r_lat == LAT_LAST);
  assign w_ovr      = r_addr[ADDR_WIDTH];
  assign w_addr_nxt = r_addr + ADDR_ONE;
  assign w_nxt_ovr  = w_addr_nxt[ADDR_WIDTH];
  assign w_ms_in    = MS_WIDTH'(i_rom_rd_data);

  // Sequencer FSM: ROM reads, record decode, byte handshake and delay timing.
  // An overrun check guards every transition into a read state, so the read
  // at the wrapped address is never issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_addr   <= ADDR_ZERO;
      r_lat    <= LAT_ZERO;
      r_hdr    <= LEN_END;
      r_remain <= 8'd0;
      r_first  <= 1'b0;
      r_ms     <= MS_ZERO;
      r_cyc    <= CYC_ZERO;
      r_valid  <= 1'b0;
      r_data   <= {DATA_WIDTH{1'b0}};
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (i_start) begin
            r_addr  <= ADDR_ZERO;
            r_lat   <= LAT_ZERO;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_RD_HDR;
          end
        end
        S_RD_HDR: begin
          if (w_rd_last) begin
            r_hdr   <= i_rom_rd_data;
            r_addr  <= w_addr_nxt;
            r_lat   <= LAT_ZERO;
            r_state <= S_DECODE;
          end else begin
            r_lat <= r_lat + LAT_ONE;
          end
        end
        S_DECODE: begin
          if (r_hdr == LEN_END) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else if (w_ovr) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else if (r_hdr == LEN_DLY) begin
            r_state <= S_RD_DLY;
          end else begin
            r_remain <= 8'(r_hdr);
            r_first  <= 1'b1;
            r_state  <= S_RD_BYTE;
          end
        end
        S_RD_BYTE: begin
          if (w_rd_last) begin
            r_valid <= 1'b1;
            r_data  <= i_rom_rd_data;
            r_sop   <= r_first;
            r_eop   <= (r_remain == 8'd1);
            r_first <= 1'b0;
            r_addr  <= w_addr_nxt;
            r_lat   <= LAT_ZERO;
            r_state <= S_SEND;
          end else begin
            r_lat <= r_lat + LAT_ONE;
          end
        end
        S_SEND: begin
          if (i_pkt_ready) begin
            r_valid  <= 1'b0;
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_remain <= r_remain - 8'd1;
            if (w_ovr) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else if (r_remain == 8'd1) begin
              r_state <= S_RD_HDR;
            end else begin
              r_state <= S_RD_BYTE;
            end
          end
        end
        S_RD_DLY: begin
          if (w_rd_last) begin
            r_addr <= w_addr_nxt;
            r_lat  <= LAT_ZERO;
            r_ms   <= w_ms_in;
            r_cyc  <= CYC_RELOAD;
            if (w_ms_in != MS_ZERO) begin
              r_state <= S_DELAY;
            end else if (w_nxt_ovr) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_RD_HDR;
            end
          end else begin
            r_lat <= r_lat + LAT_ONE;
          end
        end
        S_DELAY: begin
          // r_ms counts the ms still to run including the current one, so the
          // state lasts exactly D*CLK_PER_MS cycles.
          if (r_cyc != CYC_ZERO) begin
            r_cyc <= r_cyc - CYC_ONE;
          end else if (r_ms != MS_ONE) begin
            r_ms  <= r_ms - MS_ONE;
            r_cyc <= CYC_RELOAD;
          end else if (w_ovr) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_state <= S_RD_HDR;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rom_addr  = r_addr[ADDR_WIDTH-1:0];
  assign o_pkt_valid = r_valid;
  assign o_pkt_data  = r_data;
  assign o_pkt_sop   = r_sop;
  assign o_pkt_eop   = r_eop;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: doc/lcm_init_seq.md
Name: lcm_init_seq

Overview:
- Sequencer that walks the LCM init-parameter ROM (1024x8, hex-initialised) and turns its records into byte-streamed DSI command packets plus timed delays.
- Sits between the init-parameter ROM and the DSI packet builder, and runs once per start pulse after panel power-up or reset.
- Owns the ROM address bus exclusively. Presents a valid/ready byte stream with start-of-packet and end-of-packet flags downstream.

Parameters:
ADDR_WIDTH, 10, ROM address width; table depth is 2**ADDR_WIDTH
DATA_WIDTH, 8, ROM word / stream byte width
ROM_LAT, 1, ROM read latency in clk cycles (1 = unregistered output, 2 = output register); legal values 1..2
CLK_PER_MS, 50000, clk cycles per millisecond for delay records
MS_WIDTH, 8, width of the delay-count byte

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse: begin sequence at address 0
rom_addr  out  ADDR_WIDTH  ROM read address
rom_rd_data  in  DATA_WIDTH  ROM read data, valid ROM_LAT cycles after rom_addr changes
pkt_valid  out  1  pkt_data holds a valid byte
pkt_ready  in  1  downstream accepts byte when pkt_valid & pkt_ready
pkt_data  out  DATA_WIDTH  packet byte; first byte is the DCS command
pkt_sop  out  1  first byte of packet (qualified by pkt_valid)
pkt_eop  out  1  last byte of packet (qualified by pkt_valid)
busy  out  1  sequence in progress
done  out  1  sticky: table end reached; cleared by start or rst
err  out  1  sticky: address overrun before end record; cleared by start or rst

Behaviour:
- Reset values: rom_addr=0, pkt_valid=0, pkt_data=0, pkt_sop=0, pkt_eop=0, busy=0, done=0, err=0, state=IDLE. rst takes priority over every other input. Reset mid-packet or mid-delay aborts with no further output; the next start begins at address 0.
- Record format at the current address:
  - LEN byte = 0x00: end of table.
  - LEN byte = 0xFF: delay record; the next byte is D, the wait time in ms.
  - LEN byte = 1..0xFE: packet of LEN bytes following the LEN byte.
- States: IDLE, RD_HDR, DECODE, RD_BYTE, SEND, RD_DLY, DELAY, FIN.
- IDLE:
  - start -> rom_addr=0, busy=1, done=0, err=0, go to RD_HDR.
  - start is ignored in every state except IDLE and FIN.
- RD_* states:
  - Hold rom_addr stable for exactly ROM_LAT cycles.
  - Capture rom_rd_data on the last of those cycles.
  - Increment rom_addr on the capture cycle.
- DECODE, by LEN:
  - LEN=0 -> FIN.
  - LEN=0xFF -> RD_DLY.
  - Otherwise load remaining-count = LEN -> RD_BYTE.
- RD_BYTE -> SEND:
  - pkt_valid=1, pkt_data=captured byte.
  - pkt_sop=1 on the first byte of the record.
  - pkt_eop=1 when remaining-count = 1.
- SEND:
  - pkt_valid, pkt_data, pkt_sop and pkt_eop are held unchanged while pkt_ready=0.
  - On handshake, drop pkt_valid and decrement remaining-count.
  - Then go to RD_BYTE if bytes remain, else RD_HDR.
  - No gap-free streaming required; at least ROM_LAT idle cycles separate bytes.
- RD_DLY -> DELAY:
  - Load ms counter = D and cycle counter = CLK_PER_MS-1.
  - D=0 -> directly to RD_HDR.
- DELAY:
  - Cycle counter decrements to 0, then reloads while the ms counter decrements.
  - Exit to RD_HDR after exactly D*CLK_PER_MS cycles in DELAY.
- Overrun:
  - Any read required at address 2**ADDR_WIDTH (the address counter wraps to 0) -> err=1, go to FIN, without issuing that read.
  - A packet truncated by overrun never asserts pkt_eop; pkt_valid drops immediately.
- FIN: busy=0, done=1 (done and err sticky). start -> same as IDLE start.
- busy=1 in all states except IDLE and FIN.
- Counter widths:
  - Remaining-count is 8 bits.
  - Cycle counter is wide enough for CLK_PER_MS-1.
  - The address counter is one bit wider than ADDR_WIDTH to detect overrun.

Test Plan:
- ROM {0x02,0x11,0x00,0x00}, ROM_LAT=1, pkt_ready=1, start -> two bytes out:
  - 0x11 with sop=1, eop=0
  - 0x00 with sop=0, eop=1
  - then done=1, busy=0, err=0
- Same ROM with pkt_ready toggling 0/1 every 3 cycles -> pkt_data/sop/eop stable while valid & !ready; exactly 2 handshakes; identical byte sequence.
- ROM {0xFF,0x03,0x01,0x29,0x00}, CLK_PER_MS=10:
  - exactly 30 cycles in DELAY
  - then single byte 0x29 with sop=eop=1
  - then done=1
- ROM {0xFF,0x00,0x00} -> no stall, no packets, done=1 within 10 cycles.
- ROM_LAT=2, ROM {0x03,0x36,0x00,0xAA,0x00} -> bytes 0x36,0x00,0xAA with eop only on 0xAA; rom_addr held 2 cycles per read.
- ROM filled with 0x01,0x55 repeated to address 1023, no end record -> 512 single-byte packets, then err=1, done=1, busy=0.
- Also assert rst mid-DELAY -> all outputs at reset values next cycle; a subsequent start replays from address 0.
